// File: rtl/fir_delay_pkg.sv
// Shared types and ring-address helpers for the multichannel FIR delay stage.
package fir_delay_pkg;

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  // Where a channel's output sample comes from, decided when its RAM access is issued.
  typedef enum logic [1:0] {SRC_ZERO, SRC_BYPASS, SRC_RAM} src_t;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int delay_width(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  // A delay equal to max_delay folds back onto wr_ptr itself, so the RAM must return the pre-write word.
  function automatic int ring_addr(input int ch, input int wr_ptr, input int delay, input int max_delay);
    int slot;
    slot = wr_ptr + max_delay - delay;
    if (slot >= max_delay) slot = slot - max_delay;
    return ch * max_delay + slot;
  endfunction

endpackage

// File: rtl/fir_delay_ring_ram.sv
// Simple dual-port ring storage: synchronous read, read-before-write on address collision.
module fir_delay_ring_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/fir_delay_multichannel.sv
// N time-multiplexed channels delayed by a programmable 0..MAX_DELAY frames through one shared ring RAM.
// Build option FIR_DELAY_WARMUP_VALID_EN: hold off DATA_VALID until the ring holds the full programmed delay.
module fir_delay_multichannel
  import fir_delay_pkg::*;
#(
  parameter int  BITWIDTH_DATA = 16,
  parameter int  N_CHANNELS    = 4,
  parameter int  MAX_DELAY     = 32,
  localparam int DW            = delay_width(MAX_DELAY)
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                EN,
  input  logic                                START_FLAG,
  input  logic [N_CHANNELS*BITWIDTH_DATA-1:0] DATA_IN,
  input  logic                                DELAY_LOAD,
  input  logic [DW-1:0]                       DELAY_IN,
  output logic [N_CHANNELS*BITWIDTH_DATA-1:0] DATA_OUT,
  output logic                                DATA_VALID,
  output logic                                BUSY,
  output logic                                OVERRUN
);

  localparam int DEPTH = N_CHANNELS * MAX_DELAY;
  localparam int AW    = addr_width(DEPTH);
  localparam int CW    = addr_width(N_CHANNELS);
  localparam int PW    = addr_width(MAX_DELAY);

  state_t                                   r_state;
  logic [N_CHANNELS-1:0][BITWIDTH_DATA-1:0] r_frame;
  logic [N_CHANNELS-1:0][BITWIDTH_DATA-1:0] r_out_buf;
  logic [CW-1:0]                            r_ch_idx;
  logic [CW-1:0]                            r_rd_ch;
  logic [PW-1:0]                            r_wr_ptr;
  logic [DW-1:0]                            r_delay;
  logic [DW-1:0]                            r_warmup;
  logic [DW-1:0]                            r_pend_delay;
  logic                                     r_pend_valid;
  logic                                     r_rd_valid;
  src_t                                     r_rd_src;

  logic [DW-1:0]            w_delay_clamped;
  logic [DW-1:0]            w_next_delay;
  logic                     w_issue;
  logic                     w_finish;
  logic                     w_load_now;
  logic                     w_apply_pend;
  logic                     w_underfill;
  src_t                     w_src;
  logic [AW-1:0]            w_rd_addr;
  logic [AW-1:0]            w_wr_addr;
  logic [BITWIDTH_DATA-1:0] w_ram_rdata;

  assign w_delay_clamped = (DELAY_IN > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : DELAY_IN;
  assign w_issue         = EN && (r_state == PROC);
  // DONE lingers one cycle so the last channel's registered RAM read can land in r_out_buf.
  assign w_finish        = (r_state == DONE) && !r_rd_valid;
  assign w_load_now      = DELAY_LOAD && ((r_state == IDLE) || w_finish);
  assign w_apply_pend    = w_finish && r_pend_valid;
  assign w_next_delay    = w_load_now ? w_delay_clamped : (w_apply_pend ? r_pend_delay : r_delay);
  assign w_underfill     = (r_warmup < r_delay);
  assign w_src           = (r_delay == '0) ? SRC_BYPASS : (w_underfill ? SRC_ZERO : SRC_RAM);
  assign w_rd_addr       = AW'(ring_addr(int'(r_ch_idx), int'(r_wr_ptr), int'(r_delay), MAX_DELAY));
  assign w_wr_addr       = AW'(ring_addr(int'(r_ch_idx), int'(r_wr_ptr), 0, MAX_DELAY));

  fir_delay_ring_ram #(
    .WIDTH (BITWIDTH_DATA),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ring (
    .i_clk   (CLK),
    .i_we    (w_issue),
    .i_waddr (w_wr_addr),
    .i_wdata (r_frame[r_ch_idx]),
    .i_re    (w_issue),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_rdata)
  );

  // Delay changes arriving mid-frame are parked and applied at frame completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_frame      <= '0;
      r_out_buf    <= '0;
      r_ch_idx     <= '0;
      r_rd_ch      <= '0;
      r_wr_ptr     <= '0;
      r_delay      <= '0;
      r_warmup     <= '0;
      r_pend_delay <= '0;
      r_pend_valid <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_src     <= SRC_ZERO;
      DATA_OUT     <= '0;
      DATA_VALID   <= 1'b0;
      BUSY         <= 1'b0;
      OVERRUN      <= 1'b0;
    end else if (EN) begin
      DATA_VALID <= 1'b0;
      r_rd_valid <= (r_state == PROC);
      r_rd_ch    <= r_ch_idx;
      r_rd_src   <= w_src;

      if (r_rd_valid) begin
        case (r_rd_src)
          SRC_RAM:    r_out_buf[r_rd_ch] <= w_ram_rdata;
          SRC_BYPASS: r_out_buf[r_rd_ch] <= r_frame[r_rd_ch];
          default:    r_out_buf[r_rd_ch] <= '0;
        endcase
      end

      if (START_FLAG && (r_state != IDLE)) OVERRUN <= 1'b1;

      r_delay <= w_next_delay;
      if (w_load_now) begin
        r_pend_valid <= 1'b0;
      end else if (DELAY_LOAD) begin
        r_pend_valid <= 1'b1;
        r_pend_delay <= w_delay_clamped;
      end else if (w_finish) begin
        r_pend_valid <= 1'b0;
      end

      if ((w_load_now || w_apply_pend) && (w_next_delay != r_delay)) begin
        r_warmup <= '0;
      end else if (w_finish && (r_warmup < DW'(MAX_DELAY))) begin
        r_warmup <= r_warmup + DW'(1);
      end

      case (r_state)
        IDLE: begin
          BUSY <= START_FLAG;
          if (START_FLAG) begin
            r_frame  <= DATA_IN;
            r_ch_idx <= '0;
            r_state  <= PROC;
          end
        end
        PROC: begin
          if (r_ch_idx == CW'(N_CHANNELS - 1)) begin
            r_ch_idx <= '0;
            r_state  <= DONE;
          end else begin
            r_ch_idx <= r_ch_idx + CW'(1);
          end
        end
        DONE: begin
          if (w_finish) begin
            DATA_OUT <= r_out_buf;
`ifdef FIR_DELAY_WARMUP_VALID_EN
            DATA_VALID <= !w_underfill;
`else
            DATA_VALID <= 1'b1;
`endif
            r_wr_ptr <= (r_wr_ptr == PW'(MAX_DELAY - 1)) ? '0 : r_wr_ptr + PW'(1);
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fir_delay_multichannel.md
Name: fir_delay_multichannel

Overview:
- Parametrised successor to the single-channel FIR all-pass/delay stage: N time-multiplexed channels, each delayed by a runtime-programmable number of frames (0..MAX_DELAY).
- Sits between the ADC frame front-end and the downstream FIR/spike-detection chain; aligns channel group delay without resynthesis.
- Storage is one shared ring buffer, addressed by channel and frame pointer, serviced sequentially one channel per clock.

Parameters:
- BITWIDTH_DATA, 16, sample width per channel (unsigned bits, passed through untouched).
- N_CHANNELS, 4, number of channels per frame (>=1).
- MAX_DELAY, 32, maximum delay in frames; ring depth per channel (>=1).
- DW, $clog2(MAX_DELAY+1), width of delay value (localparam).

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  enable; low freezes all state, START_FLAG/DELAY_LOAD ignored, outputs hold.
- START_FLAG  in  1  one-cycle strobe: DATA_IN holds a new frame.
- DATA_IN  in  N_CHANNELS*BITWIDTH_DATA  packed frame, channel 0 in LSBs.
- DELAY_LOAD  in  1  strobe: latch DELAY_IN.
- DELAY_IN  in  DW  requested delay in frames; values >MAX_DELAY clamp to MAX_DELAY.
- DATA_OUT  out  N_CHANNELS*BITWIDTH_DATA  packed delayed frame.
- DATA_VALID  out  1  one-cycle pulse: DATA_OUT updated.
- BUSY  out  1  high while processing a frame.
- OVERRUN  out  1  sticky: START_FLAG arrived while BUSY; cleared only by RST.

Behaviour:
- Reset (async, RST=1): state IDLE, wr_ptr=0, ch_idx=0, delay_reg=0, DATA_OUT=0, DATA_VALID=0, BUSY=0, OVERRUN=0, warm-up counter=0. Buffer RAM is not cleared; warm-up logic hides stale content.
- FSM states: IDLE, PROC, DONE.
  - IDLE: START_FLAG & EN -> capture DATA_IN to frame_reg, ch_idx=0, go PROC.
  - PROC: one channel per cycle. Read addr = ch_idx*MAX_DELAY + (wr_ptr + MAX_DELAY - delay_reg) mod MAX_DELAY. Write frame_reg[ch_idx] at ch_idx*MAX_DELAY + wr_ptr. Read returns the pre-write value (read-before-write, required when delay_reg==MAX_DELAY). At ch_idx==N_CHANNELS-1 go DONE.
  - DONE: assert DATA_VALID for one cycle with DATA_OUT updated. wr_ptr = (wr_ptr==MAX_DELAY-1)?0:wr_ptr+1. Return to IDLE.
- delay_reg==0: bypass; DATA_OUT channel = frame_reg channel. RAM is still written.
- Latency: START_FLAG sampled at edge t; DATA_VALID high in cycle t+N_CHANNELS+2 (+1 if RAM read is registered; fixed to registered read). BUSY is high from t+1 until DATA_VALID inclusive.
- Throughput: one frame per N_CHANNELS+3 cycles. START_FLAG while BUSY is dropped and sets OVERRUN. The in-flight frame is unaffected.
- DELAY_LOAD:
  - Accepted any cycle with EN=1.
  - If BUSY, it is applied after DONE, so the current frame uses the old delay consistently.
  - Simultaneous DELAY_LOAD and START_FLAG in IDLE: the new delay applies to that frame.
- Warm-up counter: saturates at MAX_DELAY, increments at DONE, resets on RST and on any DELAY_LOAD that changes delay_reg.
- Output of a frame whose delay exceeds available history (warm-up < delay_reg): zero samples.
- EN deassert mid-PROC: FSM freezes and resumes at the same ch_idx when EN returns.

Optional Feature:
- Macro FIR_DELAY_WARMUP_VALID_EN.
- Defined: DATA_VALID is suppressed while warm-up counter < delay_reg; the first valid frame is the first fully delayed one.
- Undefined: DATA_VALID pulses every frame; under-filled frames output zeros as above.

Decomposition:
- Package fir_delay_pkg: state enum (IDLE/PROC/DONE), function for ring address computation, DW/address-width helpers.
- One sub-module: fir_delay_ring_ram, a simple dual-port RAM with synchronous read and read-before-write, depth N_CHANNELS*MAX_DELAY, inferable as BRAM.

Test Plan:
- Reset then delay 0, N=4, frame {4,3,2,1} -> DATA_VALID after N+3 cycles, DATA_OUT={4,3,2,1}, BUSY high exactly N+3 cycles.
- Delay 3, frames k=1..8 with ch c = 10k+c -> frames 1-3 zero output, frame k>=4 outputs 10(k-3)+c. With macro: first DATA_VALID on frame 4.
- Delay MAX_DELAY=32, 70 frames -> output = input 32 frames earlier across wr_ptr wrap (read-before-write at equal address).
- START_FLAG again 2 cycles after first -> second frame ignored, OVERRUN=1 and stays 1, first frame output correct.
- DELAY_LOAD 5->2 during PROC -> current frame uses 5, next uses 2 with warm-up restarted (zeros for 2 frames). DELAY_IN=40 clamps to 32.
- EN low for 5 cycles mid-PROC, and async RST mid-PROC -> EN: resumes, output correct and delayed by 5 cycles. RST: all outputs 0 immediately, next frame treated as post-reset.
